// File: rtl/buffer_write_multibank_addr_gen.sv
// Multi-bank write address generator: counts accepted beats per bank, rotates banks, stalls on unreleased banks.
// Optional sticky overflow detection is built when BUFFER_WRADDR_OVERFLOW_DETECT_EN is defined.
module buffer_write_multibank_addr_gen #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 16,
    parameter int NUM_BANKS   = 2,
    localparam int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic                   count_up_i,
    input  logic [ADDR_WIDTH-1:0]  limit_i,
    input  logic                   bank_release_i,
    output logic [COUNT_WIDTH-1:0] global_count_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [BANK_W-1:0]      bank_o,
    output logic                   we_o,
    output logic                   half_pass_o,
    output logic                   bank_full_o,
    output logic [NUM_BANKS-1:0]   bank_ready_o,
    output logic                   stall_o,
    output logic                   overflow_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [ADDR_WIDTH:0] FULL_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [BANK_W-1:0]   LAST_BANK  = BANK_W'(NUM_BANKS - 1);

    logic [1:0]             state_reg, state_next;
    logic [ADDR_WIDTH:0]    limit_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [BANK_W-1:0]      bank_reg, rd_bank_reg;
    logic [BANK_W-1:0]      bank_succ, rd_bank_succ;
    logic [NUM_BANKS-1:0]   ready_reg, ready_next;
    logic [NUM_BANKS-1:0]   release_hit, set_hit, ready_after_rel;
    logic                   full_pulse_reg;
    logic                   accept, last_beat, complete, release_ok;

    assign we_o      = count_up_i & (state_reg == ST_FILL);
    assign stall_o   = (state_reg == ST_WAIT);
    assign accept    = we_o;
    assign last_beat = ({1'b0, addr_reg} == (limit_reg - (ADDR_WIDTH+1)'(1)));
    assign complete  = accept & last_beat;

    // Releases only ever free the oldest full bank; a release with nothing full is a no-op.
    assign release_ok = bank_release_i & (state_reg != ST_IDLE) & ready_reg[rd_bank_reg];

    assign bank_succ    = (bank_reg == LAST_BANK) ? '0 : bank_reg + 1'b1;
    assign rd_bank_succ = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + 1'b1;

    // Release is applied before the completion set, so a same-index collision leaves the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign release_hit[gi]     = release_ok & (rd_bank_reg == BANK_W'(gi));
            assign set_hit[gi]         = complete & (bank_reg == BANK_W'(gi));
            assign ready_after_rel[gi] = ready_reg[gi] & ~release_hit[gi];
            assign ready_next[gi]      = ready_after_rel[gi] | set_hit[gi];
        end
    endgenerate

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_FILL: begin
                state_next = ST_FILL;
                if (complete && ready_after_rel[bank_succ])
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_WAIT;
                if (!ready_reg[bank_reg])
                    state_next = ST_FILL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            limit_reg      <= FULL_LIMIT;
            count_reg      <= '0;
            addr_reg       <= '0;
            bank_reg       <= '0;
            rd_bank_reg    <= '0;
            ready_reg      <= '0;
            full_pulse_reg <= 1'b0;
        end else if (clear_i) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            addr_reg       <= '0;
            bank_reg       <= '0;
            rd_bank_reg    <= '0;
            ready_reg      <= '0;
            full_pulse_reg <= 1'b0;
        end else if (start_i) begin
            state_reg      <= ST_FILL;
            limit_reg      <= (limit_i == '0) ? FULL_LIMIT : {1'b0, limit_i};
            count_reg      <= '0;
            addr_reg       <= '0;
            bank_reg       <= '0;
            rd_bank_reg    <= '0;
            ready_reg      <= '0;
            full_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= ready_next;
            full_pulse_reg <= complete;
            if (release_ok)
                rd_bank_reg <= rd_bank_succ;
            if (accept) begin
                count_reg <= count_reg + 1'b1;
                if (last_beat) begin
                    addr_reg <= '0;
                    bank_reg <= bank_succ;
                end else begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end
        end
    end

`ifdef BUFFER_WRADDR_OVERFLOW_DETECT_EN
    logic overflow_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow_reg <= 1'b0;
        else if (clear_i || start_i)
            overflow_reg <= 1'b0;
        else if (count_up_i && (state_reg != ST_FILL))
            overflow_reg <= 1'b1;
    end

    assign overflow_o = overflow_reg;
`else
    assign overflow_o = 1'b0;
`endif

    assign global_count_o = count_reg;
    assign addr_o         = addr_reg;
    assign bank_o         = bank_reg;
    assign bank_ready_o   = ready_reg;
    assign bank_full_o    = full_pulse_reg;
    assign half_pass_o    = ({1'b0, addr_reg} >= (limit_reg >> 1));

endmodule

// File: doc/buffer_write_multibank_addr_gen.md
Name: buffer_write_multibank_addr_gen

Overview:
- Multi-bank (ping-pong generalised to N banks) write address generator for the matrix-multiplier input/result buffers.
- Counts accepted write beats against a limit programmed at start, rotates across NUM_BANKS banks, and tracks which banks hold unconsumed data.
- Stalls the producer when it would overwrite a bank the consumer has not yet released.
- Sits between the stream producer (count_up_i) and the buffer RAM write port; the consumer releases banks in order.

Parameters:
- ADDR_WIDTH, 10, per-bank address width; bank depth 2^ADDR_WIDTH.
- COUNT_WIDTH, 16, width of the global beat counter.
- NUM_BANKS, 2, number of banks; must be >= 2. BANK_W = $clog2(NUM_BANKS).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a new fill sequence; latches limit_i.
- clear_i  in  1  synchronous return to IDLE.
- count_up_i  in  1  one write beat offered this cycle.
- limit_i  in  ADDR_WIDTH  beats per bank; 0 means 2^ADDR_WIDTH.
- bank_release_i  in  1  consumer frees the oldest full bank.
- global_count_o  out  COUNT_WIDTH  accepted beats since start, wraps modulo 2^COUNT_WIDTH.
- addr_o  out  ADDR_WIDTH  write address within the current bank.
- bank_o  out  BANK_W  current write bank.
- we_o  out  1  count_up_i accepted this cycle (combinational: count_up_i & state==FILL).
- half_pass_o  out  1  addr_o >= limit/2.
- bank_full_o  out  1  one-cycle pulse, the cycle after a bank completes.
- bank_ready_o  out  NUM_BANKS  per-bank "full, not yet released" flags.
- stall_o  out  1  producer must hold; beats are not accepted.
- overflow_o  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (async): state=IDLE. All counters, addr_o, bank_o, rd_bank, bank_ready_o, bank_full_o, overflow_o = 0. Latched limit L = 2^ADDR_WIDTH.
- L is held internally as ADDR_WIDTH+1 bits: L = (limit_i==0) ? 2^ADDR_WIDTH : limit_i.
- States: IDLE, FILL, WAIT_FREE.
- Priority per cycle: clear_i > start_i > count_up_i/bank_release_i.
- clear_i: next cycle state=IDLE; counters, addr, bank, rd_bank, bank_ready, overflow all 0.
- start_i, from any state: latch L; zero global count, addr, bank, rd_bank and bank_ready; state=FILL. A count_up_i in the same cycle is dropped.
- IDLE: count_up_i and bank_release_i are ignored. stall_o=0 and we_o=0.
- FILL: each count_up_i is accepted with 1-cycle latency to the outputs. global_count +1 and addr +1.
- Accepted beat at addr==L-1 completes the bank:
  - bank_ready[bank] <= 1; bank_full_o pulses next cycle; addr <= 0.
  - bank <= (bank==NUM_BANKS-1) ? 0 : bank+1.
  - If bank_ready[next bank] is 1 and not released this same cycle, state <= WAIT_FREE; otherwise stay in FILL.
- WAIT_FREE: stall_o=1 (combinational from state), we_o=0, count_up_i is not accepted. Return to FILL on the cycle after bank_ready[bank_o] is cleared.
- bank_release_i: if bank_ready[rd_bank]==1, clear it and advance rd_bank modulo NUM_BANKS. If no bank is ready, ignore it (no error).
- Completing a bank and releasing the same bank index in one cycle: the release applies to the old flag first, then the set applies, so the flag ends up 1.
- half_pass_o = (addr_o >= L>>1), combinational from registered state.
- Limit 1: every accepted beat completes a bank; half_pass_o stays 1.
- global_count_o wraps silently; it does not affect bank logic.
- Reset mid-operation aborts immediately. No partial-bank flag remains.

Optional Feature:
- Macro: BUFFER_WRADDR_OVERFLOW_DETECT_EN.
- Defined: overflow_o <= 1 when count_up_i is asserted while stall_o=1, or while in IDLE. It stays set until clear_i, start_i or reset.
- Not defined: overflow_o tied to 0; the overflow register is not built. Dropped beats are silent.

Test Plan:
- Reset, start_i with limit_i=4, NUM_BANKS=2, 4 beats -> addr_o 0,1,2,3,0; bank_o 0→1; bank_full_o pulses once; bank_ready_o=2'b01; half_pass_o rises at addr 2; global_count_o=4.
- Fill 8 beats with L=4 and no release -> bank_ready_o=2'b11; stall_o=1; 9th beat dropped; global_count_o stays 8; overflow_o=1 when the macro is defined, 0 when not.
- From the stalled state, pulse bank_release_i -> bank_ready_o=2'b10; stall_o drops within 2 cycles; next beat writes bank 0 addr 0.
- limit_i=0, ADDR_WIDTH=3 -> bank completes after 8 beats; half_pass_o at addr 4.
- Bank completes in the same cycle bank_release_i frees the next bank -> no stall; FILL continues without a gap.
- clear_i together with count_up_i mid-fill -> next cycle IDLE, all outputs 0. Later beats are ignored until start_i.
